encoder_case: RTL and testbench



---
 rtl/encoder_pkg.sv | 26 ++
 rtl/encoder_prio_core.sv | 18 +
 rtl/encoder_case.sv | 60 ++++++
 tb/tb_encoder_case.sv | 129 ++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared types, widths and the priority-encode function for the encoder_case block.
package encoder_pkg;

    localparam int ENC_WIDTH = 8;
    localparam int ENC_OUT_W = 3;

    typedef logic [ENC_WIDTH-1:0] enc_in_t;
    typedef logic [ENC_OUT_W-1:0] enc_idx_t;

    // Highest set bit wins; an all-zero vector maps to index 0.
    function automatic enc_idx_t f_prio_idx(input enc_in_t v);
        enc_idx_t r;
        casez (v)
            8'b1???_????: r = 3'd7;
            8'b01??_????: r = 3'd6;
            8'b001?_????: r = 3'd5;
            8'b0001_????: r = 3'd4;
            8'b0000_1???: r = 3'd3;
            8'b0000_01??: r = 3'd2;
            8'b0000_001?: r = 3'd1;
            default:      r = 3'd0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/encoder_prio_core.sv
// Combinational half of the encoder: priority index, any-bit and multi-bit flags.
module encoder_prio_core
    import encoder_pkg::*;
(
    input  logic [7:0] inp,
    output logic [2:0] idx,
    output logic       any,
    output logic       many
);

    // Clearing the lowest set bit leaves something only when two or more bits were set.
    always_comb begin
        idx  = f_prio_idx(inp);
        any  = |inp;
        many = ((inp & (inp - 8'd1)) != 8'd0);
    end

endmodule

// File: rtl/encoder_case.sv
// Registered 8-to-3 priority encoder with all-zero and multi-hot flags.
module encoder_case
    import encoder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int OUT_W = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] inp,
    output logic [2:0] outp,
    output logic       valid,
    output logic       multi
);

    // Only the 8-bit / 3-bit configuration exists; reject anything else at elaboration.
    if (WIDTH != ENC_WIDTH || OUT_W != $clog2(WIDTH)) begin : g_bad_param
        $error("encoder_case: unsupported WIDTH/OUT_W combination");
    end

    enc_idx_t idx_d;
    logic     any_d;
    logic     many_d;

    enc_idx_t outp_q;
    logic     valid_q;
    logic     multi_q;

    encoder_prio_core u_core (
        .inp  (inp),
        .idx  (idx_d),
        .any  (any_d),
        .many (many_d)
    );

    // Single output register stage; reset wins over the input sampled on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            outp_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            outp_q  <= idx_d;
            valid_q <= any_d;
            multi_q <= many_d;
        end
    end

    assign outp  = outp_q;
    assign valid = valid_q;
    assign multi = multi_q;

`ifndef SYNTHESIS
    a_zero_when_invalid : assert property (@(posedge clk) disable iff (rst)
        (!valid_q |-> (outp_q == 3'd0)));
    a_multi_implies_valid : assert property (@(posedge clk) disable iff (rst)
        (multi_q |-> valid_q));
`endif

endmodule

// File: tb/tb_encoder_case.sv
// Randomized and directed bench for encoder_case against a loop-based model.
module tb_encoder_case;

    logic       clk;
    logic       rst;
    logic [7:0] inp;
    logic [2:0] outp;
    logic       valid;
    logic       multi;

    int vectors;
    int miscompares;

    logic [2:0] exp_outp;
    logic       exp_valid;
    logic       exp_multi;

    encoder_case #(.WIDTH(8), .OUT_W(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .inp   (inp),
        .outp  (outp),
        .valid (valid),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int model_hi(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    function automatic int model_pop(input logic [7:0] v);
        int n = 0;
        for (int i = 0; i < 8; i++) n += v[i];
        return n;
    endfunction

    task automatic cmp(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Apply one input for one edge, advance the model, then check DUT against model.
    task automatic step(input logic r, input logic [7:0] v);
        int pc;
        rst = r;
        inp = v;
        @(posedge clk);
        pc = model_pop(v);
        if (r) begin
            exp_outp  = 3'd0;
            exp_valid = 1'b0;
            exp_multi = 1'b0;
        end else begin
            exp_outp  = 3'(model_hi(v));
            exp_valid = (pc >= 1);
            exp_multi = (pc >= 2);
        end
        @(negedge clk);
        cmp("outp", int'(outp), int'(exp_outp));
        cmp("valid", int'(valid), int'(exp_valid));
        cmp("multi", int'(multi), int'(exp_multi));
    endtask

    // Hand-computed expectation: pins both the DUT and the model.
    task automatic lit(input string name, input int o, input int vl, input int m);
        cmp({name, ".outp"}, int'(outp), o);
        cmp({name, ".valid"}, int'(valid), vl);
        cmp({name, ".multi"}, int'(multi), m);
        cmp({name, ".model_outp"}, int'(exp_outp), o);
        cmp({name, ".model_multi"}, int'(exp_multi), m);
    endtask

    initial begin
        logic [7:0] v;
        logic       r;
        int         mode;
        vectors     = 0;
        miscompares = 0;
        rst = 1'b1;
        inp = 8'h00;
        @(negedge clk);

        step(1'b1, 8'hFF); lit("reset0", 0, 0, 0);
        step(1'b1, 8'hFF); lit("reset1", 0, 0, 0);

        for (int i = 0; i < 8; i++) begin
            v = 8'd1 << i;
            step(1'b0, v);
            lit("sweep", i, 1, 0);
        end
        step(1'b0, 8'b1000_0000); lit("msb", 7, 1, 0);
        step(1'b0, 8'b0000_0010); lit("bit1", 1, 1, 0);

        step(1'b0, 8'b0010_0000); lit("pre_zero", 5, 1, 0);
        step(1'b0, 8'h00);        lit("zero", 0, 0, 0);

        step(1'b0, 8'b1000_0010); lit("multi82", 7, 1, 1);
        step(1'b0, 8'b0001_1000); lit("multi18", 4, 1, 1);
        step(1'b0, 8'hFF);        lit("multiFF", 7, 1, 1);

        step(1'b0, 8'b0100_0000); lit("mid_pre", 6, 1, 0);
        step(1'b1, 8'b0100_0000); lit("mid_rst", 0, 0, 0);
        step(1'b0, 8'b0100_0000); lit("mid_post", 6, 1, 0);

        for (int n = 0; n < 1000; n++) begin
            mode = int'($urandom_range(0, 9));
            case (mode)
                0:       v = 8'h00;
                1, 2, 3: v = 8'd1 << $urandom_range(0, 7);
                default: v = 8'($urandom);
            endcase
            r = ($urandom_range(0, 49) == 0);
            step(r, v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
